traffic_light_controller: RTL and testbench

TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

---
 rtl/traffic_light_pkg.sv | 24 ++
 rtl/tlc_phase_timer.sv | 24 ++
 rtl/traffic_light_controller.sv | 136 +++++++++++++
 tb/tb_traffic_light_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light controller: state encodings,
// state width, lamp patterns (R,Y,G order) and a sizing helper.
package traffic_light_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Dwell counter for the traffic light controller. Clears when the FSM
// changes state (restart), otherwise counts up and saturates at all-ones.
// rst is asynchronous active-low.
module tlc_phase_timer #(
    parameter int unsigned COUNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    output logic [COUNT_W-1:0] count
);

    // Saturating dwell count, restarted on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road traffic light controller: main road rests on green until a
// side/pedestrian request is latched and the minimum green dwell is met.
// Optional macro TLC_ALL_RED_EN inserts all-red clearance states between
// yellow and the opposite green; without it the all-red codes are
// unreachable and recover to MAIN_GREEN. rst is asynchronous active-low.
module traffic_light_controller #(
    parameter int unsigned MAIN_GREEN_MIN  = 4,
    parameter int unsigned YELLOW_TIME     = 2,
    parameter int unsigned SIDE_GREEN_TIME = 3,
    parameter int unsigned ALL_RED_TIME    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic main_red,
    output logic main_yellow,
    output logic main_green,
    output logic side_red,
    output logic side_yellow,
    output logic side_green
);

    import traffic_light_pkg::*;

    localparam int unsigned MAX_TIME = max_of(max_of(MAIN_GREEN_MIN, YELLOW_TIME),
                                              max_of(SIDE_GREEN_TIME, ALL_RED_TIME));
    localparam int unsigned COUNT_W  = $clog2(MAX_TIME + 1);

    localparam logic [COUNT_W-1:0] MG_LAST = COUNT_W'(MAIN_GREEN_MIN - 1);
    localparam logic [COUNT_W-1:0] Y_LAST  = COUNT_W'(YELLOW_TIME - 1);
    localparam logic [COUNT_W-1:0] SG_LAST = COUNT_W'(SIDE_GREEN_TIME - 1);
`ifdef TLC_ALL_RED_EN
    localparam logic [COUNT_W-1:0] AR_LAST = COUNT_W'(ALL_RED_TIME - 1);
`endif

    state_t             state;
    state_t             next_state;
    logic               req;
    logic               take_req;
    logic [COUNT_W-1:0] count;
    logic [2:0]         main_lamps;
    logic [2:0]         side_lamps;

    tlc_phase_timer #(
        .COUNT_W (COUNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (next_state != state),
        .count   (count)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MAIN_GREEN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; unlisted codes recover to MAIN_GREEN
    always_comb begin
        next_state = state;
        take_req   = 1'b0;
        case (state)
            MAIN_GREEN: begin
                if (req && (count >= MG_LAST)) begin
                    next_state = MAIN_YELLOW;
                    take_req   = 1'b1;
                end
            end
            MAIN_YELLOW: begin
                if (count == Y_LAST) begin
`ifdef TLC_ALL_RED_EN
                    next_state = ALL_RED_A;
`else
                    next_state = SIDE_GREEN;
`endif
                end
            end
`ifdef TLC_ALL_RED_EN
            ALL_RED_A: begin
                if (count == AR_LAST) next_state = SIDE_GREEN;
            end
            ALL_RED_B: begin
                if (count == AR_LAST) next_state = MAIN_GREEN;
            end
`endif
            SIDE_GREEN: begin
                if (count == SG_LAST) next_state = SIDE_YELLOW;
            end
            SIDE_YELLOW: begin
                if (count == Y_LAST) begin
`ifdef TLC_ALL_RED_EN
                    next_state = ALL_RED_B;
`else
                    next_state = MAIN_GREEN;
`endif
                end
            end
            default: next_state = MAIN_GREEN;
        endcase
    end

    // Request latch: serving the request beats a coincident press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req <= 1'b0;
        end else if (take_req) begin
            req <= 1'b0;
        end else if (button && (state != SIDE_GREEN) && (state != SIDE_YELLOW)) begin
            req <= 1'b1;
        end
    end

    // Moore lamp decode from state
    always_comb begin
        main_lamps = LAMP_RED;
        side_lamps = LAMP_RED;
        case (state)
            MAIN_GREEN:  main_lamps = LAMP_GREEN;
            MAIN_YELLOW: main_lamps = LAMP_YELLOW;
            SIDE_GREEN:  side_lamps = LAMP_GREEN;
            SIDE_YELLOW: side_lamps = LAMP_YELLOW;
            default: begin
                main_lamps = LAMP_RED;
                side_lamps = LAMP_RED;
            end
        endcase
    end

    assign {main_red, main_yellow, main_green} = main_lamps;
    assign {side_red, side_yellow, side_green} = side_lamps;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench for traffic_light_controller: the driver pushes the
// hand-derived expected state for each cycle, the monitor pops and checks
// state and lamps on the falling edge. Expectations follow TLC_ALL_RED_EN.
module tb_traffic_light_controller;

    import traffic_light_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic button;
    logic main_red, main_yellow, main_green;
    logic side_red, side_yellow, side_green;
    logic [5:0] lamps;

    int checks = 0;
    int errors = 0;

    typedef struct {
        state_t st;
        int     idx;
        string  tag;
    } exp_t;

    exp_t        sb[$];
    state_t      plan[$];
    logic [63:0] pulses = '0;

    always #5 clk = ~clk;

    assign lamps = {main_red, main_yellow, main_green, side_red, side_yellow, side_green};

    traffic_light_controller #(
        .MAIN_GREEN_MIN  (4),
        .YELLOW_TIME     (2),
        .SIDE_GREEN_TIME (3),
        .ALL_RED_TIME    (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .main_red    (main_red),
        .main_yellow (main_yellow),
        .main_green  (main_green),
        .side_red    (side_red),
        .side_yellow (side_yellow),
        .side_green  (side_green)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endfunction

    function automatic logic [5:0] lamp_model(input state_t s);
        case (s)
            MAIN_GREEN:  return 6'b001_100;
            MAIN_YELLOW: return 6'b010_100;
            SIDE_GREEN:  return 6'b100_001;
            SIDE_YELLOW: return 6'b100_010;
            default:     return 6'b100_100;
        endcase
    endfunction

    // Monitor: one expected entry per cycle, checked mid-cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s[%0d] state", e.tag, e.idx), 32'(dut.state), 32'(e.st));
            chk($sformatf("%s[%0d] lamps", e.tag, e.idx), 32'(lamps), 32'(lamp_model(e.st)));
        end
    end

    task automatic add(input state_t s, input int n);
        for (int i = 0; i < n; i++) plan.push_back(s);
    endtask

    // Drive one cycle per plan entry; called at posedge+1 (start of cycle 0)
    task automatic run(input string tag);
        exp_t e;
        for (int i = 0; i < plan.size(); i++) begin
            button = pulses[i];
            e.st   = plan[i];
            e.idx  = i;
            e.tag  = tag;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        button = 1'b0;
        plan.delete();
        pulses = '0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " state"}, 32'(dut.state), 32'(MAIN_GREEN));
        chk({tag, " req"}, 32'(dut.req), 32'd0);
        chk({tag, " count"}, 32'(dut.u_timer.count), 32'd0);
        chk({tag, " lamps"}, 32'(lamps), 32'(6'b001_100));
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        button = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One full side cycle after the main-yellow entry point
    task automatic add_side_cycle();
        add(MAIN_YELLOW, 2);
`ifdef TLC_ALL_RED_EN
        add(ALL_RED_A, 1);
`endif
        add(SIDE_GREEN, 3);
        add(SIDE_YELLOW, 2);
`ifdef TLC_ALL_RED_EN
        add(ALL_RED_B, 1);
`endif
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        // Idle: 32+ cycles of green; late press tests counter saturation
        do_reset();
        pulses[32] = 1'b1;
        add(MAIN_GREEN, 34);
        add(MAIN_YELLOW, 2);
        run("idle_sat");

        // Press at cycle 6: two-edge latency, full side cycle, return to main
        do_reset();
        pulses[6] = 1'b1;
        add(MAIN_GREEN, 8);
        add_side_cycle();
        add(MAIN_GREEN, 6);
        run("press6");

        // Press at cycle 1: main green held exactly the 4-cycle minimum
        do_reset();
        pulses[1] = 1'b1;
        add(MAIN_GREEN, 4);
        add_side_cycle();
        add(MAIN_GREEN, 2);
        run("press1");

        // Press on the yellow-entry edge is swallowed; side-phase presses ignored
        do_reset();
        pulses[1] = 1'b1;
        pulses[3] = 1'b1;
`ifdef TLC_ALL_RED_EN
        pulses[8]  = 1'b1;
        pulses[11] = 1'b1;
`else
        pulses[7]  = 1'b1;
        pulses[10] = 1'b1;
`endif
        add(MAIN_GREEN, 4);
        add_side_cycle();
        add(MAIN_GREEN, 8);
        run("ignored");

        // Press latched outside main green is served after the minimum dwell
        do_reset();
        pulses[1] = 1'b1;
`ifdef TLC_ALL_RED_EN
        pulses[12] = 1'b1;
`else
        pulses[5] = 1'b1;
`endif
        add(MAIN_GREEN, 4);
        add_side_cycle();
        add(MAIN_GREEN, 4);
        add(MAIN_YELLOW, 2);
`ifdef TLC_ALL_RED_EN
        add(ALL_RED_A, 1);
`endif
        add(SIDE_GREEN, 1);
        run("latched");

        // Reset asserted mid side-green takes effect without a clock edge
        do_reset();
        pulses[1] = 1'b1;
        add(MAIN_GREEN, 4);
        add(MAIN_YELLOW, 2);
`ifdef TLC_ALL_RED_EN
        add(ALL_RED_A, 1);
`endif
        add(SIDE_GREEN, 2);
        run("pre_rst");
        chk("pre_rst side_green", 32'(dut.state), 32'(SIDE_GREEN));
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        #1;
        check_reset_values("held_rst");
        rst = 1'b1;
        chk("release count", 32'(dut.u_timer.count), 32'd0);
        add(MAIN_GREEN, 6);
        run("after_rst");
        chk("after_rst count", 32'(dut.u_timer.count), 32'd6);

        repeat (2) @(posedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
